emesh_tx_packer: RTL and testbench

- Upstream feeder for the elink transmit-side host channels (txwr_*, txrd_*).
- Accepts host commands on a single valid/ready interface and checks address alignment.
- Packs each command into a 104-bit emesh packet and buffers it in a per-channel FIFO (write vs read).
- Drives the elink txwr/txrd access/packet pair and honours the elink wait back-pressure.

---
 rtl/emesh_tx_packer.sv | 181 ++++++++++++++++++
 tb/tb_emesh_tx_packer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emesh_tx_packer.sv
// emesh_tx_packer
//   Upstream feeder for the elink transmit host channels. Host commands arrive
//   on one valid/ready port, are checked for address alignment, packed into a
//   104-bit emesh packet and buffered in one FIFO per channel (write / read).
//   Each FIFO head drives the matching elink access/packet pair and honours
//   the elink wait back-pressure.
//
// Handshake rules (used on every interface of this block):
//   A transfer happens at a rising clock edge where valid (or access) is 1 and
//   ready is 1 (or wait is 0). A producer holds its payload stable until the
//   transfer happens. cmd_ready never depends on txwr_wait / txrd_wait.
//
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     host command handshake
//   cmd_write                 1 = write (txwr channel), 0 = read (txrd channel)
//   cmd_datamode              0 byte, 1 half, 2 word, 3 double
//   cmd_ctrlmode, cmd_dstaddr, cmd_data, cmd_srcaddr   packet fields
//   txwr_access/packet/wait   write channel toward elink
//   txrd_access/packet/wait   read channel toward elink
//   wr_level, rd_level        FIFO occupancy (0..DEPTH)
//   drop_count                saturating count of misaligned commands dropped
//
// Packet layout: [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr,
//                [71:40] data, [103:72] srcaddr.

module emesh_tx_fifo #(
  parameter int PW    = 104,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [PW-1:0]            din,
  input  logic                     pop,
  output logic [PW-1:0]            dout,
  output logic                     not_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign not_empty = (level != '0);
  assign full      = (level == LVL_FULL);
  // Guards keep the FIFO self-consistent even if a caller misbehaves.
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & not_empty;
  // An empty FIFO presents zeros so the packet output reads 0 after reset
  // without having to clear the storage array.
  assign dout      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; validity is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

module emesh_tx_packer #(
  parameter int PW    = 104,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [1:0]               cmd_datamode,
  input  logic [4:0]               cmd_ctrlmode,
  input  logic [31:0]              cmd_dstaddr,
  input  logic [31:0]              cmd_data,
  input  logic [31:0]              cmd_srcaddr,
  output logic                     txwr_access,
  output logic [PW-1:0]            txwr_packet,
  input  logic                     txwr_wait,
  output logic                     txrd_access,
  output logic [PW-1:0]            txrd_packet,
  input  logic                     txrd_wait,
  output logic [$clog2(DEPTH):0]   wr_level,
  output logic [$clog2(DEPTH):0]   rd_level,
  output logic [CW-1:0]            drop_count
);

  localparam logic [CW-1:0] DROP_MAX = '1;
  localparam logic [CW-1:0] DROP_ONE = CW'(1);

  logic          aligned;
  logic          accept;
  logic          wr_push;
  logic          rd_push;
  logic          wr_pop;
  logic          rd_pop;
  logic          wr_full;
  logic          rd_full;
  logic [PW-1:0] cmd_packet;

  // Datamode n requires the low n address bits to be zero.
  always_comb begin
    aligned = 1'b1;
    case (cmd_datamode)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~cmd_dstaddr[0];
      2'd2:    aligned = ~|cmd_dstaddr[1:0];
      default: aligned = ~|cmd_dstaddr[2:0];
    endcase
  end

  assign cmd_packet = {cmd_srcaddr, cmd_data, cmd_dstaddr,
                       cmd_ctrlmode, cmd_datamode, cmd_write};

  // Ready follows only the selected FIFO's fullness. A misaligned command is
  // still accepted (and dropped) only when that FIFO has room, which keeps
  // cmd_ready a function of FIFO state and cmd_write alone.
  assign cmd_ready = cmd_write ? ~wr_full : ~rd_full;
  assign accept    = cmd_valid & cmd_ready;
  assign wr_push   = accept & aligned &  cmd_write;
  assign rd_push   = accept & aligned & ~cmd_write;
  assign wr_pop    = txwr_access & ~txwr_wait;
  assign rd_pop    = txrd_access & ~txrd_wait;

  emesh_tx_fifo #(.PW(PW), .DEPTH(DEPTH)) u_wr_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_push),
    .din       (cmd_packet),
    .pop       (wr_pop),
    .dout      (txwr_packet),
    .not_empty (txwr_access),
    .full      (wr_full),
    .level     (wr_level)
  );

  emesh_tx_fifo #(.PW(PW), .DEPTH(DEPTH)) u_rd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_push),
    .din       (cmd_packet),
    .pop       (rd_pop),
    .dout      (txrd_packet),
    .not_empty (txrd_access),
    .full      (rd_full),
    .level     (rd_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && !aligned && drop_count != DROP_MAX) begin
      drop_count <= drop_count + DROP_ONE;
    end
  end

endmodule

// File: tb/tb_emesh_tx_packer.sv
// Self-checking bench for emesh_tx_packer: table of directed vectors,
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a queue-based reference model of the two channels.

module tb_emesh_tx_packer;

  localparam int PW    = 104;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clock;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [1:0]      cmd_datamode;
  logic [4:0]      cmd_ctrlmode;
  logic [31:0]     cmd_dstaddr;
  logic [31:0]     cmd_data;
  logic [31:0]     cmd_srcaddr;
  logic            txwr_access;
  logic [PW-1:0]   txwr_packet;
  logic            txwr_wait;
  logic            txrd_access;
  logic [PW-1:0]   txrd_packet;
  logic            txrd_wait;
  logic [LW-1:0]   wr_level;
  logic [LW-1:0]   rd_level;
  logic [CW-1:0]   drop_count;

  emesh_tx_packer #(.PW(PW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_datamode (cmd_datamode),
    .cmd_ctrlmode (cmd_ctrlmode),
    .cmd_dstaddr  (cmd_dstaddr),
    .cmd_data     (cmd_data),
    .cmd_srcaddr  (cmd_srcaddr),
    .txwr_access  (txwr_access),
    .txwr_packet  (txwr_packet),
    .txwr_wait    (txwr_wait),
    .txrd_access  (txrd_access),
    .txrd_packet  (txrd_packet),
    .txrd_wait    (txrd_wait),
    .wr_level     (wr_level),
    .rd_level     (rd_level),
    .drop_count   (drop_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] wr_exp_q[$];
  logic [PW-1:0] rd_exp_q[$];
  int unsigned   drop_m = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic w, input logic [1:0] dm,
                                         input logic [4:0] ctrl, input logic [31:0] dst,
                                         input logic [31:0] data, input logic [31:0] src);
    return {src, data, dst, ctrl, dm, w};
  endfunction

  // Reference model: each channel is a plain queue of packets. A command is
  // taken when valid and the chosen queue holds fewer than DEPTH packets; it
  // is kept if the address is a multiple of the access size, else counted as
  // dropped. The queue head leaves whenever the channel is not stalled.
  always @(negedge clock) begin
    int unsigned size_bytes;
    logic        model_ready;
    if (reset) begin
      wr_exp_q.delete();
      rd_exp_q.delete();
      drop_m = 0;
    end else begin
      chk("wr_level", wr_level, wr_exp_q.size());
      chk("wr_access", txwr_access, wr_exp_q.size() != 0);
      if (wr_exp_q.size() != 0) chk("wr_packet", txwr_packet, wr_exp_q[0]);
      else                      chk("wr_packet_idle", txwr_packet, 0);
      chk("rd_level", rd_level, rd_exp_q.size());
      chk("rd_access", txrd_access, rd_exp_q.size() != 0);
      if (rd_exp_q.size() != 0) chk("rd_packet", txrd_packet, rd_exp_q[0]);
      else                      chk("rd_packet_idle", txrd_packet, 0);
      if (txrd_access) chk("rd_write_bit", txrd_packet[0], 1'b0);
      chk("drop_count", drop_count, drop_m);
      model_ready = cmd_write ? (wr_exp_q.size() < DEPTH) : (rd_exp_q.size() < DEPTH);
      chk("cmd_ready", cmd_ready, model_ready);
      if (wr_exp_q.size() != 0 && !txwr_wait) void'(wr_exp_q.pop_front());
      if (rd_exp_q.size() != 0 && !txrd_wait) void'(rd_exp_q.pop_front());
      if (cmd_valid && model_ready) begin
        size_bytes = 1 << cmd_datamode;
        if ((cmd_dstaddr % size_bytes) == 0) begin
          if (cmd_write) wr_exp_q.push_back(pack(cmd_write, cmd_datamode, cmd_ctrlmode,
                                                 cmd_dstaddr, cmd_data, cmd_srcaddr));
          else           rd_exp_q.push_back(pack(cmd_write, cmd_datamode, cmd_ctrlmode,
                                                 cmd_dstaddr, cmd_data, cmd_srcaddr));
        end else if (drop_m < (1 << CW) - 1) begin
          drop_m++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic w, input logic [1:0] dm, input logic [4:0] ctrl,
                      input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
    int n;
    n = 0;
    cmd_valid    = 1'b1;
    cmd_write    = w;
    cmd_datamode = dm;
    cmd_ctrlmode = ctrl;
    cmd_dstaddr  = dst;
    cmd_data     = data;
    cmd_srcaddr  = src;
    @(negedge clock);
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready0 expected=ready1 at %0t", $time);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        w;
    logic [1:0]  dm;
    logic [4:0]  ctrl;
    logic [31:0] dst;
    logic [31:0] data;
    logic [31:0] src;
    logic        exp_emit;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vt[8];

  logic [PW-1:0] p_stall [5];
  logic          accepted5;
  logic [31:0]   a;

  initial begin
    vt[0] = '{1'b1, 2'd2, 5'd0,  32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_0810, 1'b1, 8'd0};
    vt[1] = '{1'b1, 2'd2, 5'd1,  32'h8000_0002, 32'h1111_1111, 32'h0000_0820, 1'b0, 8'd1};
    vt[2] = '{1'b1, 2'd3, 5'd2,  32'h0000_1004, 32'h2222_2222, 32'h0000_0830, 1'b0, 8'd2};
    vt[3] = '{1'b0, 2'd0, 5'd3,  32'h0000_0003, 32'h3333_3333, 32'h0000_0840, 1'b1, 8'd2};
    vt[4] = '{1'b0, 2'd1, 5'd4,  32'h0000_0006, 32'h4444_4444, 32'h0000_0850, 1'b1, 8'd2};
    vt[5] = '{1'b0, 2'd1, 5'd5,  32'h0000_0005, 32'h5555_5555, 32'h0000_0860, 1'b0, 8'd3};
    vt[6] = '{1'b1, 2'd3, 5'd31, 32'h0000_0008, 32'h6666_6666, 32'h0000_0870, 1'b1, 8'd3};
    vt[7] = '{1'b0, 2'd3, 5'd16, 32'h1000_0010, 32'h7777_7777, 32'h0000_0880, 1'b1, 8'd3};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_datamode = 2'd0; cmd_ctrlmode = 5'd0;
    cmd_dstaddr = '0; cmd_data = '0; cmd_srcaddr = '0;
    txwr_wait = 1'b0; txrd_wait = 1'b0;
    idle(3);
    reset = 1'b0;

    // Reset state
    chk("rst_wr_access", txwr_access, 1'b0);
    chk("rst_rd_access", txrd_access, 1'b0);
    chk("rst_wr_level", wr_level, 0);
    chk("rst_rd_level", rd_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_wr_packet", txwr_packet, 0);
    chk("rst_rd_packet", txrd_packet, 0);
    chk("rst_ready_rd", cmd_ready, 1'b1);
    cmd_write = 1'b1;
    #1;
    chk("rst_ready_wr", cmd_ready, 1'b1);
    cmd_write = 1'b0;
    idle(1);

    // Directed vectors: emitted exactly one cycle after acceptance, for one cycle
    for (int i = 0; i < 8; i++) begin
      send(vt[i].w, vt[i].dm, vt[i].ctrl, vt[i].dst, vt[i].data, vt[i].src);
      @(negedge clock);
      if (vt[i].w) begin
        chk("vec_wr_emit", txwr_access, vt[i].exp_emit);
        if (vt[i].exp_emit)
          chk("vec_wr_packet", txwr_packet,
              pack(vt[i].w, vt[i].dm, vt[i].ctrl, vt[i].dst, vt[i].data, vt[i].src));
      end else begin
        chk("vec_rd_emit", txrd_access, vt[i].exp_emit);
        if (vt[i].exp_emit)
          chk("vec_rd_packet", txrd_packet,
              pack(vt[i].w, vt[i].dm, vt[i].ctrl, vt[i].dst, vt[i].data, vt[i].src));
      end
      if (i == 0)
        chk("first_write_packet", txwr_packet,
            {32'h0000_0810, 32'hDEAD_BEEF, 32'h8000_0004, 5'd0, 2'd2, 1'b1});
      chk("vec_drop", drop_count, vt[i].exp_drop);
      @(negedge clock);
      chk("vec_one_cycle_wr", txwr_access, 1'b0);
      chk("vec_one_cycle_rd", txrd_access, 1'b0);
      chk("vec_level_back", wr_level, 0);
      @(posedge clock);
      #1;
    end

    // Stall: 4 writes fill the FIFO, the 5th waits for room
    txwr_wait = 1'b1;
    for (int i = 0; i < 5; i++)
      p_stall[i] = pack(1'b1, 2'd2, 5'(i), 32'h4000_0000 + 32'(i * 4), $urandom, 32'h900 + 32'(i));
    for (int i = 0; i < 4; i++)
      send(1'b1, 2'd2, 5'(i), 32'h4000_0000 + 32'(i * 4), p_stall[i][71:40], 32'h900 + 32'(i));
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_datamode = 2'd2; cmd_ctrlmode = 5'd4;
    cmd_dstaddr = 32'h4000_0010; cmd_data = p_stall[4][71:40]; cmd_srcaddr = 32'h904;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_ready", cmd_ready, 1'b0);
      chk("stall_level", wr_level, 4);
      chk("stall_packet", txwr_packet, p_stall[0]);
      @(posedge clock);
      #1;
    end
    txwr_wait = 1'b0;
    accepted5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("drain_access", txwr_access, 1'b1);
      chk("drain_packet", txwr_packet, p_stall[i]);
      if (cmd_valid && cmd_ready) accepted5 = 1'b1;
      @(posedge clock);
      #1;
      if (accepted5) cmd_valid = 1'b0;
    end
    chk("fifth_accepted", accepted5, 1'b1);
    @(negedge clock);
    chk("fifth_packet", txwr_packet, p_stall[4]);
    idle(3);

    // Misaligned drops and saturation
    do_reset();
    send(1'b1, 2'd2, 5'd0, 32'h1234_5672, 32'h0, 32'h0);
    send(1'b1, 2'd3, 5'd0, 32'h1234_5674, 32'h0, 32'h0);
    @(negedge clock);
    chk("mis_no_access", txwr_access, 1'b0);
    chk("mis_drop2", drop_count, 2);
    @(posedge clock);
    #1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom << 1) | 32'h1;
      send(i[0], 2'd0, 5'($urandom), a, $urandom, $urandom);
    end
    idle(2);
    chk("byte_no_drop", drop_count, 2);
    for (int i = 0; i < 260; i++) begin
      a = ($urandom << 1) | 32'h1;
      send(i[0], 2'($urandom_range(1, 3)), 5'd0, a, $urandom, $urandom);
    end
    idle(2);
    chk("drop_saturate", drop_count, 255);
    chk("sat_wr_level", wr_level, 0);

    // Independent channels: reads stalled, writes flow
    do_reset();
    txrd_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'd1, 5'(i), 32'h2000_0000 + 32'(i * 2), $urandom, 32'h700 + 32'(i));
      send(1'b0, 2'd2, 5'(i), 32'h3000_0000 + 32'(i * 4), $urandom, 32'h600 + 32'(i));
    end
    idle(2);
    chk("ind_rd_level", rd_level, 4);
    chk("ind_wr_level", wr_level, 0);
    txrd_wait = 1'b0;
    idle(6);
    chk("ind_rd_drained", rd_level, 0);

    // Steady simultaneous push/pop at level 2
    txwr_wait = 1'b1;
    send(1'b1, 2'd2, 5'd1, 32'h5000_0000, $urandom, 32'h1);
    send(1'b1, 2'd2, 5'd2, 32'h5000_0004, $urandom, 32'h2);
    txwr_wait = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 2'd2, 5'($urandom), 32'h5000_0008 + 32'(i * 4), $urandom, $urandom);
      chk("steady_level", wr_level, 2);
    end
    idle(4);
    chk("steady_drained", wr_level, 0);

    // Asynchronous reset mid-stall
    txwr_wait = 1'b1;
    for (int i = 0; i < 3; i++)
      send(1'b1, 2'd0, 5'd0, 32'h6000_0000 + 32'(i), $urandom, 32'h3);
    chk("pre_reset_level", wr_level, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_access", txwr_access, 1'b0);
    chk("async_rst_level", wr_level, 0);
    chk("async_rst_packet", txwr_packet, 0);
    txwr_wait = 1'b0;
    idle(2);
    reset = 1'b0;
    send(1'b1, 2'd2, 5'd9, 32'h7000_0010, 32'hCAFE_F00D, 32'h0000_0ABC);
    @(negedge clock);
    chk("post_reset_access", txwr_access, 1'b1);
    chk("post_reset_packet", txwr_packet,
        {32'h0000_0ABC, 32'hCAFE_F00D, 32'h7000_0010, 5'd9, 2'd2, 1'b1});
    @(posedge clock);
    #1;
    idle(2);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic acc;
      acc = 1'b0;
      if (!cmd_valid) begin
        cmd_valid    = ($urandom_range(0, 3) != 0);
        cmd_write    = $urandom_range(0, 1);
        cmd_datamode = $urandom_range(0, 3);
        cmd_ctrlmode = $urandom;
        a            = $urandom;
        if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
        cmd_dstaddr  = a;
        cmd_data     = $urandom;
        cmd_srcaddr  = $urandom;
      end
      txwr_wait = ($urandom_range(0, 9) < 3);
      txrd_wait = ($urandom_range(0, 9) < 4);
      @(negedge clock);
      acc = cmd_valid && cmd_ready;
      @(posedge clock);
      #1;
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    txwr_wait = 1'b0;
    txrd_wait = 1'b0;
    idle(10);
    chk("final_wr_empty", wr_level, 0);
    chk("final_rd_empty", rd_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
